// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//
// Collects NUM_EXT asynchronous external interrupt lines and an optional
// machine timer. It arbitrates among the enabled pending sources and raises
// a single trap request with an mcause value toward the CSR stage.
//
// Build option:
//   INTC_TIMER_EN  - when defined, the mtime/mtimecmp timer and its interrupt
//                    source are present. When undefined, mtime and mtimecmp
//                    read 0, writes to them are dropped, the timer never
//                    requests, and mask bit 0 reads 0.
//
// Ports:
//   clk       in   single clock, all state changes on posedge
//   rst       in   asynchronous active-low reset
//   ext_irq   in   [NUM_EXT] asynchronous external interrupt lines
//   wr_en     in   register write strobe
//   addr      in   [4] byte address: 0x0 mtime, 0x4 mtimecmp, 0x8 pending,
//                  0xC mask; any other address reads 0 and ignores writes
//   wdata     in   [32] write data
//   rdata     out  [32] combinational read data for addr
//   trap_ack  in   CSR stage accepted the trap
//   is_mret   in   handler return executed
//   trap      out  trap request (registered)
//   cause     out  [32] mcause of the current trap (registered)
//
// Register map:
//   0x8 pending : bits [NUM_EXT-1:0] = latched external edges, write 1 to clear
//   0xC mask    : bit 0 = timer enable, bits [NUM_EXT:1] = ext line enables
// -----------------------------------------------------------------------------
module interrupt_controller #(
   parameter int NUM_EXT = 4,
   parameter int TIMER_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_EXT-1:0] ext_irq,
   input  logic               wr_en,
   input  logic [3:0]         addr,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata,
   input  logic               trap_ack,
   input  logic               is_mret,
   output logic               trap,
   output logic [31:0]        cause
);

   localparam logic [3:0]  ADDR_MTIME    = 4'h0;
   localparam logic [3:0]  ADDR_MTIMECMP = 4'h4;
   localparam logic [3:0]  ADDR_PENDING  = 4'h8;
   localparam logic [3:0]  ADDR_MASK     = 4'hC;

   localparam logic [31:0] CAUSE_TIMER   = 32'h8000_0007;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_SERVICE = 2'd2
   } state_t;

   state_t             state_reg;
   logic               trap_reg;
   logic [31:0]        cause_reg;
   // One-hot of the external line being serviced (all zero for the timer);
   // used to auto-clear that pending bit when the trap is accepted.
   logic [NUM_EXT-1:0] svc_onehot_reg;

   // ------------------------------------------------------------------
   // Register write decode
   // ------------------------------------------------------------------
   logic wr_pending;
   logic wr_mask;

   assign wr_pending = wr_en && (addr == ADDR_PENDING);
   assign wr_mask    = wr_en && (addr == ADDR_MASK);

   // ------------------------------------------------------------------
   // External line synchronizers and rising-edge detection
   // ------------------------------------------------------------------
   logic [NUM_EXT-1:0] sync1_reg;
   logic [NUM_EXT-1:0] sync2_reg;
   logic [NUM_EXT-1:0] prev_reg;
   logic [2:0]         warm_reg;
   logic [NUM_EXT-1:0] rise;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
         prev_reg  <= '0;
         warm_reg  <= '0;
      end else begin
         sync1_reg <= ext_irq;
         sync2_reg <= sync1_reg;
         prev_reg  <= sync2_reg;
         warm_reg  <= {warm_reg[1:0], 1'b1};
      end
   end

   // The edge flop only holds a real sample of the line three cycles after
   // reset release. Until then its reset value of 0 would make a line that
   // was already high look like a fresh rising edge, so edge detection is
   // held off until the warm-up shift register has filled.
   assign rise = sync2_reg & ~prev_reg & {NUM_EXT{warm_reg[2]}};

   // ------------------------------------------------------------------
   // Pending register (external sources only)
   // ------------------------------------------------------------------
   logic [NUM_EXT-1:0] pending_reg;
   logic [NUM_EXT-1:0] pending_next;
   logic [NUM_EXT-1:0] wclr;
   logic [NUM_EXT-1:0] ack_clr;

   assign wclr    = wr_pending ? wdata[NUM_EXT-1:0] : '0;
   assign ack_clr = ((state_reg == S_REQ) && trap_ack) ? svc_onehot_reg : '0;

   // A new edge on the same cycle as a clear (software or auto) wins, so an
   // interrupt arriving exactly as the old one is cleared is never lost.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_EXT; gi++) begin : g_pend
         assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~(wclr[gi] | ack_clr[gi]));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_reg <= '0;
      end else begin
         pending_reg <= pending_next;
      end
   end

   // ------------------------------------------------------------------
   // Mask register: bit 0 timer, bits [NUM_EXT:1] external lines
   // ------------------------------------------------------------------
   logic [NUM_EXT:0] mask_reg;
   logic             mask_timer_wbit;

`ifdef INTC_TIMER_EN
   assign mask_timer_wbit = wdata[0];
`else
   assign mask_timer_wbit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mask_reg <= '0;
      end else if (wr_mask) begin
         mask_reg <= {wdata[NUM_EXT:1], mask_timer_wbit};
      end
   end

   // ------------------------------------------------------------------
   // Machine timer
   // ------------------------------------------------------------------
   logic        timer_req;
   logic [31:0] mtime_rd;
   logic [31:0] mtimecmp_rd;

`ifdef INTC_TIMER_EN
   logic [TIMER_W-1:0] mtime_reg;
   logic [TIMER_W-1:0] mtimecmp_reg;
   logic               timer_pend_reg;
   logic               wr_mtime;
   logic               wr_mtimecmp;

   assign wr_mtime    = wr_en && (addr == ADDR_MTIME);
   assign wr_mtimecmp = wr_en && (addr == ADDR_MTIMECMP);

   // timer_pend is sticky: once mtime reaches mtimecmp it stays set even if
   // mtime later wraps below mtimecmp. Only rewriting mtimecmp drops it; the
   // comparison is then re-evaluated against the new value next cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mtime_reg      <= '0;
         mtimecmp_reg   <= '1;
         timer_pend_reg <= 1'b0;
      end else begin
         if (wr_mtime) begin
            mtime_reg <= TIMER_W'(wdata);
         end else begin
            mtime_reg <= mtime_reg + 1'b1;
         end
         if (wr_mtimecmp) begin
            mtimecmp_reg   <= TIMER_W'(wdata);
            timer_pend_reg <= 1'b0;
         end else begin
            timer_pend_reg <= timer_pend_reg | (mtime_reg >= mtimecmp_reg);
         end
      end
   end

   assign timer_req   = timer_pend_reg & mask_reg[0];
   assign mtime_rd    = 32'(mtime_reg);
   assign mtimecmp_rd = 32'(mtimecmp_reg);
`else
   logic [TIMER_W-1:0] unused_timer_w;

   assign unused_timer_w = '0;
   assign timer_req      = 1'b0;
   assign mtime_rd       = '0;
   assign mtimecmp_rd    = '0;
`endif

   // Not every wdata bit lands in a register for every configuration.
   logic unused_wdata;
   assign unused_wdata = ^wdata;

   // ------------------------------------------------------------------
   // Arbitration: timer first, then lowest-numbered external line
   // ------------------------------------------------------------------
   logic [NUM_EXT-1:0]        ext_req;
   logic [NUM_EXT-1:0]        ext_first;
   logic [NUM_EXT:0][7:0]     idx_chain;
   logic [3:0]                ext_idx;
   logic                      any_req;
   logic [31:0]               win_cause;
   logic [NUM_EXT-1:0]        win_onehot;

   assign ext_req = pending_reg & mask_reg[NUM_EXT:1];

   // Two's-complement trick isolates the lowest set bit.
   assign ext_first = ext_req & (~ext_req + NUM_EXT'(1));

   // Encode the one-hot winner into its line number.
   assign idx_chain[0] = 8'd0;
   generate
      for (gi = 0; gi < NUM_EXT; gi++) begin : g_enc
         assign idx_chain[gi+1] = idx_chain[gi] | (ext_first[gi] ? 8'(gi) : 8'd0);
      end
   endgenerate
   assign ext_idx = idx_chain[NUM_EXT][3:0];

   always_comb begin
      any_req    = timer_req | (|ext_req);
      win_cause  = {12'h800, ext_idx, 16'h000B};
      win_onehot = ext_first;
      if (timer_req) begin
         win_cause  = CAUSE_TIMER;
         win_onehot = '0;
      end
   end

   // ------------------------------------------------------------------
   // Trap FSM
   // ------------------------------------------------------------------
   // cause and the serviced source are frozen on IDLE->REQ; later mask or
   // pending changes cannot retract or alter an outstanding request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= S_IDLE;
         trap_reg       <= 1'b0;
         cause_reg      <= '0;
         svc_onehot_reg <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (any_req) begin
                  state_reg      <= S_REQ;
                  trap_reg       <= 1'b1;
                  cause_reg      <= win_cause;
                  svc_onehot_reg <= win_onehot;
               end
            end
            S_REQ: begin
               if (trap_ack) begin
                  state_reg <= S_SERVICE;
                  trap_reg  <= 1'b0;
               end
            end
            S_SERVICE: begin
               if (is_mret) begin
                  state_reg <= S_IDLE;
               end
            end
            default: begin
               state_reg <= S_IDLE;
               trap_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign trap  = trap_reg;
   assign cause = cause_reg;

   // ------------------------------------------------------------------
   // Read mux
   // ------------------------------------------------------------------
   always_comb begin
      rdata = '0;
      case (addr)
         ADDR_MTIME:    rdata = mtime_rd;
         ADDR_MTIMECMP: rdata = mtimecmp_rd;
         ADDR_PENDING:  rdata = 32'(pending_reg);
         ADDR_MASK:     rdata = 32'(mask_reg);
         default:       rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

   localparam int NUM_EXT = 4;
   localparam int TIMER_W = 32;

`ifdef INTC_TIMER_EN
   localparam bit TIMER_ON = 1'b1;
`else
   localparam bit TIMER_ON = 1'b0;
`endif

   localparam logic [3:0] A_MTIME = 4'h0;
   localparam logic [3:0] A_CMP   = 4'h4;
   localparam logic [3:0] A_PEND  = 4'h8;
   localparam logic [3:0] A_MASK  = 4'hC;

   logic               clk = 1'b0;
   logic               rst;
   logic [NUM_EXT-1:0] ext_irq;
   logic               wr_en;
   logic [3:0]         addr;
   logic [31:0]        wdata;
   logic [31:0]        rdata;
   logic               trap_ack;
   logic               is_mret;
   logic               trap;
   logic [31:0]        cause;

   int n_checks = 0;
   int n_fail   = 0;

   interrupt_controller #(.NUM_EXT(NUM_EXT), .TIMER_W(TIMER_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .ext_irq  (ext_irq),
      .wr_en    (wr_en),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .trap_ack (trap_ack),
      .is_mret  (is_mret),
      .trap     (trap),
      .cause    (cause)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      wr_en = 1'b1;
      step();
      wr_en = 1'b0;
   endtask

   task automatic reg_read(input logic [3:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rdata;
   endtask

   task automatic pulse(input int lines);
      ext_irq = NUM_EXT'(lines);
      step();
      ext_irq = '0;
   endtask

   task automatic do_ack();
      trap_ack = 1'b1;
      step();
      trap_ack = 1'b0;
   endtask

   task automatic do_mret();
      is_mret = 1'b1;
      step();
      is_mret = 1'b0;
   endtask

   task automatic wait_trap(input string name, input int max_cycles);
      logic [31:0] seen;
      seen = 32'd0;
      for (int i = 0; i < max_cycles; i++) begin
         if (trap === 1'b1) begin
            seen = 32'd1;
            break;
         end
         step();
      end
      check(name, seen, 32'd1);
   endtask

   typedef struct {
      logic [3:0]  wa;
      logic [31:0] wd;
      logic [3:0]  ra;
      logic [31:0] exp;
   } reg_vec_t;

   reg_vec_t vecs[10];

   // Reference model for the random phase: pending set as an integer bitmask.
   int model_pend;

   function automatic int lowest_enabled(input int pend, input int en);
      for (int i = 0; i < NUM_EXT; i++) begin
         if ((((pend >> i) & 1) == 1) && (((en >> i) & 1) == 1)) return i;
      end
      return -1;
   endfunction

   initial begin
      logic [31:0] rd;
      logic [31:0] mask_all;
      int lines;
      int m;
      int want;
      int c;

      mask_all = TIMER_ON ? 32'h1F : 32'h1E;

      vecs[0] = '{A_MASK,   32'hFFFF_FFFF, A_MASK,  mask_all};
      vecs[1] = '{A_MASK,   32'h0000_0000, A_MASK,  32'h0};
      vecs[2] = '{4'hD,     32'hFFFF_FFFF, A_MASK,  32'h0};
      vecs[3] = '{4'h5,     32'hFFFF_FFFF, 4'h5,    32'h0};
      vecs[4] = '{A_PEND,   32'hFFFF_FFFF, A_PEND,  32'h0};
      vecs[5] = '{A_MASK,   32'h0000_0014, A_MASK,  32'h14};
      vecs[6] = '{4'h3,     32'h1234_5678, 4'h3,    32'h0};
      vecs[7] = '{A_CMP,    32'h0000_1234, A_CMP,   TIMER_ON ? 32'h1234 : 32'h0};
      vecs[8] = '{A_CMP,    32'hFFFF_FFFF, A_CMP,   TIMER_ON ? 32'hFFFF_FFFF : 32'h0};
      vecs[9] = '{A_MTIME,  32'h0000_0100, A_MTIME, TIMER_ON ? 32'h100 : 32'h0};

      ext_irq  = '0;
      wr_en    = 1'b0;
      addr     = '0;
      wdata    = '0;
      trap_ack = 1'b0;
      is_mret  = 1'b0;
      rst      = 1'b0;
      step(3);
      rst = 1'b1;

      // ---------------- reset state ----------------
      check("rst_trap", 32'(trap), 32'h0);
      check("rst_cause", cause, 32'h0);
      reg_read(A_PEND, rd); check("rst_pending", rd, 32'h0);
      reg_read(A_MASK, rd); check("rst_mask", rd, 32'h0);
      reg_read(A_CMP, rd);  check("rst_mtimecmp", rd, TIMER_ON ? 32'hFFFF_FFFF : 32'h0);
      step();

      // ---------------- register table ----------------
      for (int k = 0; k < 10; k++) begin
         reg_write(vecs[k].wa, vecs[k].wd);
         reg_read(vecs[k].ra, rd);
         check($sformatf("regvec%0d", k), rd, vecs[k].exp);
      end
      reg_write(A_MASK, 32'h0);

      // ---------------- basic ext[0] trap ----------------
      reg_write(A_MASK, 32'h2);
      pulse(1);
      wait_trap("ext0_trap", 6);
      check("ext0_cause", cause, 32'h8000_000B);
      reg_read(A_PEND, rd); check("ext0_pend_set", rd, 32'h1);
      do_ack();
      check("ext0_ack_trap", 32'(trap), 32'h0);
      reg_read(A_PEND, rd); check("ext0_autoclr", rd, 32'h0);
      do_mret();

      // ---------------- REQ holds, SERVICE blocks ----------------
      reg_write(A_MASK, 32'h6);
      pulse(1);
      wait_trap("req_trap", 6);
      do_mret();
      check("mret_in_req", 32'(trap), 32'h1);
      reg_write(A_MASK, 32'h0);
      reg_write(A_PEND, 32'h1);
      check("no_retract_trap", 32'(trap), 32'h1);
      check("no_retract_cause", cause, 32'h8000_000B);
      do_ack();
      check("req_ack_trap", 32'(trap), 32'h0);
      reg_write(A_MASK, 32'h6);
      pulse(2);
      step(8);
      check("service_blocks", 32'(trap), 32'h0);
      reg_read(A_PEND, rd); check("service_pend", rd, 32'h2);
      do_mret();
      wait_trap("after_mret_trap", 4);
      check("after_mret_cause", cause, 32'h8001_000B);
      do_ack();
      do_mret();

      // ---------------- ack in IDLE ignored ----------------
      reg_write(A_MASK, 32'h0);
      pulse(2);
      step(4);
      do_ack();
      reg_read(A_PEND, rd); check("ack_idle_ignored", rd, 32'h2);
      reg_write(A_PEND, 32'h2);
      reg_read(A_PEND, rd); check("w1c_clear", rd, 32'h0);

      // ---------------- set wins over simultaneous clear ----------------
      ext_irq = 4'b1000;
      step(2);
      reg_write(A_PEND, 32'h8);
      ext_irq = '0;
      reg_read(A_PEND, rd); check("set_wins", rd, 32'h8);
      reg_write(A_PEND, 32'h8);

`ifdef INTC_TIMER_EN
      // ---------------- mtime wrap ----------------
      reg_write(A_MTIME, 32'hFFFF_FFFE);
      reg_read(A_MTIME, rd); check("mtime_wr", rd, 32'hFFFF_FFFE);
      step();
      reg_read(A_MTIME, rd); check("mtime_max", rd, 32'hFFFF_FFFF);
      step();
      reg_read(A_MTIME, rd); check("mtime_wrap", rd, 32'h0);

      // ---------------- timer interrupt ----------------
      reg_write(A_MTIME, 32'h0);
      reg_write(A_CMP, 32'd20);
      reg_write(A_MASK, 32'h1);
      wait_trap("timer_trap", 40);
      reg_read(A_MTIME, rd);
      check("timer_when", 32'((rd >= 32'd21) && (rd <= 32'd23)), 32'h1);
      check("timer_cause", cause, 32'h8000_0007);
      do_ack();
      reg_write(A_CMP, 32'hFFFF_FFFF);
      do_mret();
      step(3);
      check("timer_cleared", 32'(trap), 32'h0);

      // ---------------- timer beats ext[2] ----------------
      reg_write(A_MASK, 32'h0);
      pulse(4);
      reg_write(A_MTIME, 32'h0);
      reg_write(A_CMP, 32'd5);
      step(10);
      reg_write(A_MASK, 32'h9);
      wait_trap("prio_trap1", 4);
      check("prio_cause1", cause, 32'h8000_0007);
      do_ack();
      reg_write(A_CMP, 32'hFFFF_FFFF);
      do_mret();
      wait_trap("prio_trap2", 4);
      check("prio_cause2", cause, 32'h8002_000B);
      do_ack();
      do_mret();
      reg_write(A_MASK, 32'h0);
`endif

      // ---------------- reset mid-request ----------------
      reg_write(A_MASK, 32'h2);
      pulse(1);
      wait_trap("pre_rst_trap", 6);
      #2;
      rst = 1'b0;
      ext_irq = 4'b1000;
      #1;
      check("rst_async_trap", 32'(trap), 32'h0);
      check("rst_async_cause", cause, 32'h0);
      reg_read(A_PEND, rd); check("rst_async_pend", rd, 32'h0);
      reg_read(A_MASK, rd); check("rst_async_mask", rd, 32'h0);
      step(2);
      reg_read(A_MTIME, rd); check("rst_mtime_held", rd, 32'h0);
      rst = 1'b1;
      reg_write(A_MASK, 32'h1E);
      step(10);
      check("no_edge_after_rst_trap", 32'(trap), 32'h0);
      reg_read(A_PEND, rd); check("no_edge_after_rst_pend", rd, 32'h0);
      ext_irq = '0;
      step(3);
      pulse(8);
      wait_trap("post_rst_trap", 6);
      check("post_rst_cause", cause, 32'h8003_000B);
      do_ack();
      do_mret();
      reg_write(A_MASK, 32'h0);

      // ---------------- randomized against the reference model ----------------
      model_pend = 0;
      for (int t = 0; t < 25; t++) begin
         reg_write(A_MASK, 32'h0);
         lines = int'($urandom_range(0, 15));
         pulse(lines);
         step(4);
         model_pend = model_pend | lines;
         m = int'($urandom_range(0, 15));
         reg_write(A_MASK, 32'(m) << 1);
         step(3);
         for (int it = 0; it <= NUM_EXT; it++) begin
            want = lowest_enabled(model_pend, m);
            if (want < 0) begin
               check($sformatf("rnd%0d_idle", t), 32'(trap), 32'h0);
               break;
            end
            check($sformatf("rnd%0d_trap", t), 32'(trap), 32'h1);
            check($sformatf("rnd%0d_cause", t), cause, 32'h8000_000B + 32'(want) * 32'h1_0000);
            do_ack();
            model_pend = model_pend & ~(1 << want);
            reg_read(A_PEND, rd);
            check($sformatf("rnd%0d_pend", t), rd, 32'(model_pend));
            do_mret();
            step(3);
         end
         c = int'($urandom_range(0, 15));
         reg_write(A_PEND, 32'(c));
         model_pend = model_pend & ~c;
         reg_read(A_PEND, rd);
         check($sformatf("rnd%0d_w1c", t), rd, 32'(model_pend));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter NUM_EXT, default 4, number of external interrupt lines (1..16).
REQ-002 SHALL have parameter TIMER_W, default 32, timer counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ext_irq  input  NUM_EXT  asynchronous external interrupt lines.
REQ-006 SHALL have port wr_en  input  1  register write strobe.
REQ-007 SHALL have port addr  input  4  byte address of register: 0x0 mtime, 0x4 mtimecmp, 0x8 pending, 0xC mask.
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port rdata  output  32  combinational read data for addr.
REQ-010 SHALL have port trap_ack  input  1  CSR stage accepted the trap.
REQ-011 SHALL have port is_mret  input  1  handler return executed.
REQ-012 SHALL have port trap  output  1  trap request to CSR stage.
REQ-013 SHALL have port cause  output  32  mcause value for the current trap.

Function
REQ-014 SHALL pass each ext_irq bit through a 2-flop synchronizer, then rising-edge detect.
REQ-015 SHALL set pending[i] on detected rising edge of ext_irq[i]; pending is NUM_EXT bits, upper bits of 32-bit register read 0.
REQ-016 SHALL clear pending bits by write-1-to-clear at 0x8; simultaneous edge and clear on same bit: set wins.
REQ-017 SHALL increment mtime by 1 every cycle, wrapping 2^TIMER_W-1 -> 0; write to 0x0 overrides the increment that cycle.
REQ-018 SHALL hold timer_pend = (mtime >= mtimecmp), unsigned; writing mtimecmp is the only way to clear it.
REQ-019 SHALL mask: bit 0 of mask enables timer, bits [NUM_EXT:1] enable ext lines; masked sources stay pending but do not request.
REQ-020 SHALL implement FSM IDLE, REQ, SERVICE.
REQ-021 IDLE -> REQ when any enabled source pending; cause latched that cycle, trap=1 from next cycle.
REQ-022 SHALL prioritise timer (cause 0x8000_0007) over external (cause 0x8000_000B | (i<<16), lowest i wins).
REQ-023 REQ holds trap=1 and cause stable until trap_ack; on trap_ack -> SERVICE, trap=0 next cycle, and the serviced ext pending bit auto-clears.
REQ-024 SERVICE ignores new sources (they stay pending); is_mret -> IDLE; re-arbitration possible the cycle after IDLE entry.
REQ-025 is_mret in IDLE or REQ SHALL be ignored; trap_ack outside REQ SHALL be ignored.
REQ-026 If the latched source is masked or cleared while in REQ, SHALL keep request until trap_ack (no retraction).
REQ-027 Unmapped addr SHALL read 0 and ignore writes.

Reset
REQ-028 On rst low, asynchronously: state=IDLE, trap=0, cause=0, mtime=0, mtimecmp=all ones, pending=0, mask=0, synchronizer and edge flops=0.
REQ-029 Reset mid-request SHALL drop trap immediately; no edge shall be detected on the first cycle after release for lines already high.

Configuration
REQ-030 Macro INTC_TIMER_EN: defined -> timer, mtimecmp and timer source present as above.
REQ-031 Without INTC_TIMER_EN: mtime and mtimecmp read 0, writes ignored, timer never requests, mask bit 0 reads 0.

Verification
REQ-032 mask=0x2, pulse ext_irq[0] -> trap=1 within 4 cycles, cause=0x8000_000B; ack -> trap=0, pending[0]=0.
REQ-033 mtimecmp=20, mask=0x1, mtime reset -> trap at mtime≈21, cause=0x8000_0007; write mtimecmp=all ones clears.
REQ-034 timer and ext[2] both pending, mask=0x9 -> timer first; after ack+mret -> cause=0x8002_000B.
REQ-035 mtime written 0xFFFF_FFFE -> reads 0xFFFF_FFFF, then 0x0 next cycles.
REQ-036 In SERVICE pulse ext[1] -> no trap until is_mret, then trap with cause 0x8001_000B.
REQ-037 Drop rst while trap=1 -> trap=0 same cycle, all registers at reset values.
